// File: rtl/calc_pkg.sv
// Shared key codes, sizes and FSM encoding for the calculator entry controller.
package calc_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_BKSP = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_SUB  = 4'hD;
  localparam logic [3:0] KEY_MUL  = 4'hE;
  localparam logic [3:0] KEY_EQ   = 4'hF;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_ACCEPT,
    ST_HELD
  } state_t;

  // Keys 0..9 are numeric entry; everything above is a command or operator.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Keypad-in / display-and-ALU-out bundle of the entry controller.
interface calc_entry_ctrl_if;
  logic [15:0] key_onehot;
  logic [3:0]  digit_sel;
  logic [3:0]  seg_nibble;
  logic        seg_blank;
  logic [15:0] digits;
  logic [2:0]  entry_count;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [15:0] operand;

  modport master (
    input  key_onehot,
    output digit_sel, seg_nibble, seg_blank, digits, entry_count, op_valid, op_code, operand
  );

  modport slave (
    output key_onehot,
    input  digit_sel, seg_nibble, seg_blank, digits, entry_count, op_valid, op_code, operand
  );
endinterface

// File: rtl/key_encode.sv
// One-hot keypad word to {valid, code}; more or fewer than one bit set is "no key".
module key_encode (
  input  logic [15:0] onehot,
  output logic        valid,
  output logic [3:0]  code
);
  // Single-bit check plus priority-free index of the set bit.
  always_comb begin
    valid = ($countones(onehot) == 1);
    code  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) code = 4'(i);
    end
  end
endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad debounce, 4-digit operand entry and multiplexed display scan for the calculator.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 16_000_000,
  parameter int unsigned SCAN_HZ        = 240,
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input logic            CLK,
  input logic            RST_N,
  calc_entry_ctrl_if.master bus
);
  localparam int unsigned TICK_DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned TW       = $clog2(TICK_DIV);
  localparam int unsigned CW       = $clog2(DEBOUNCE_TICKS + 1);

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          key_valid;
  logic [3:0]    key_code;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [15:0]   digits_q, digits_d;
  logic [2:0]    count_q, count_d;
  logic          op_valid_q, op_valid_d;
  logic [3:0]    op_code_q, op_code_d;
  logic [15:0]   operand_q, operand_d;

  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    nib_q, nib_d;
  logic          blank_q, blank_d;

  key_encode u_key_encode (
    .onehot (bus.key_onehot),
    .valid  (key_valid),
    .code   (key_code)
  );

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Free-running scan tick divider.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // Debounce FSM next state and the entry actions taken in ACCEPT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    digits_d   = digits_q;
    count_d    = count_q;
    op_valid_d = 1'b0;
    op_code_d  = op_code_q;
    operand_d  = operand_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tick && key_valid) begin
          cand_d = key_code;
          if (DEBOUNCE_TICKS == 1) begin
            state_d = ST_ACCEPT;
          end else begin
            state_d = ST_DEBOUNCE;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (key_valid && key_code == cand_q) begin
            if (cnt_q + CW'(1) == CW'(DEBOUNCE_TICKS)) begin
              state_d = ST_ACCEPT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      ST_ACCEPT: begin
        state_d = ST_HELD;
        cnt_d   = '0;
        if (is_digit(cand_q)) begin
          if (count_q < 3'(NUM_DIGITS)) begin
            digits_d = {digits_q[11:0], cand_q};
            count_d  = count_q + 3'd1;
          end
        end else if (cand_q == KEY_BKSP) begin
          if (count_q != 3'd0) begin
            digits_d = {4'h0, digits_q[15:4]};
            count_d  = count_q - 3'd1;
          end
        end else if (cand_q == KEY_CLR) begin
          digits_d = '0;
          count_d  = '0;
        end else begin
          op_valid_d = 1'b1;
          op_code_d  = cand_q;
          operand_d  = digits_q;
          digits_d   = '0;
          count_d    = '0;
        end
      end
      ST_HELD: begin
        // Release must be stable too, so a bouncing release cannot re-trigger.
        if (tick) begin
          if (bus.key_onehot == 16'h0) begin
            if (cnt_q + CW'(1) == CW'(DEBOUNCE_TICKS)) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan index advance and the matching select/nibble/blank triple.
  always_comb begin
    logic [1:0] p;
    idx_d   = idx_q;
    sel_d   = sel_q;
    nib_d   = nib_q;
    blank_d = blank_q;
    p       = 2'd0;
    if (tick) begin
      idx_d   = idx_q + 2'd1;
      p       = 2'd3 - idx_d;
      sel_d   = 4'b1000 >> idx_d;
      nib_d   = 4'(digits_q >> {p, 2'b00});
      blank_d = ({1'b0, p} >= count_q) && (p != 2'd0);
    end
  end

  // State, datapath and display registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      digits_q   <= '0;
      count_q    <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      operand_q  <= '0;
      idx_q      <= '0;
      sel_q      <= 4'b1000;
      nib_q      <= '0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      operand_q  <= operand_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      nib_q      <= nib_d;
      blank_q    <= blank_d;
    end
  end

  assign bus.digit_sel   = sel_q;
  assign bus.seg_nibble  = nib_q;
  assign bus.seg_blank   = blank_q;
  assign bus.digits      = digits_q;
  assign bus.entry_count = count_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.op_code     = op_code_q;
  assign bus.operand     = operand_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: TICK_DIV=4, DEBOUNCE_TICKS=3.
module tb_calc_entry_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mon_errs;
  int   pulses;
  logic prev_op;
  logic [3:0]  last_code;
  logic [15:0] last_operand;

  calc_entry_ctrl_if bus ();

  calc_entry_ctrl #(
    .CLK_FREQ       (1000),
    .SCAN_HZ        (250),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running invariants plus operator-pulse capture.
  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot(bus.digit_sel)) else begin
        mon_errs++;
        $error("FAIL onehot: observed=%b required one-hot", bus.digit_sel);
      end
      assert (!(bus.op_valid && prev_op)) else begin
        mon_errs++;
        $error("FAIL op_pulse_width: observed two consecutive op_valid, required one");
      end
      assert (bus.entry_count <= 3'd4) else begin
        mon_errs++;
        $error("FAIL count_range: observed=%0d required<=4", bus.entry_count);
      end
      if (bus.op_valid) begin
        pulses++;
        last_code    = bus.op_code;
        last_operand = bus.operand;
      end
      prev_op = bus.op_valid;
    end else begin
      prev_op = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a raw key word for 'hold' ticks, then release for 'rel' ticks.
  task automatic press(input logic [15:0] word, input int hold, input int rel);
    @(negedge clk);
    bus.key_onehot = word;
    repeat (hold * 4) @(posedge clk);
    @(negedge clk);
    bus.key_onehot = 16'h0;
    repeat (rel * 4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input int k);
    press(16'h1 << k, 4, 4);
  endtask

  // Walk one full scan and compare each digit against the entered value.
  task automatic check_display(input string tag, input logic [15:0] dig, input logic [2:0] cnt);
    int p;
    for (int n = 0; n < 4; n++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      case (bus.digit_sel)
        4'b1000: p = 3;
        4'b0100: p = 2;
        4'b0010: p = 1;
        default: p = 0;
      endcase
      check({tag, "_nib"}, {28'h0, bus.seg_nibble}, {28'h0, 4'(dig >> (4 * p))});
      check({tag, "_blank"}, {31'h0, bus.seg_blank}, {31'h0, (p >= int'(cnt)) && (p != 0)});
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    mon_errs       = 0;
    pulses         = 0;
    prev_op        = 1'b0;
    last_code      = 4'h0;
    last_operand   = 16'h0;
    bus.key_onehot = 16'h0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", {28'h0, bus.digit_sel}, 32'h8);
    check("rst_digits", {16'h0, bus.digits}, 32'h0);
    check("rst_count", {29'h0, bus.entry_count}, 32'h0);
    check("rst_opv", {31'h0, bus.op_valid}, 32'h0);
    rst_n = 1'b1;

    // 1: single digit, display shows it only in the rightmost position.
    key(5);
    check("t1_digits", {16'h0, bus.digits}, 32'h0005);
    check("t1_count", {29'h0, bus.entry_count}, 32'd1);
    check_display("t1", 16'h0005, 3'd1);

    // 2: clear, then fill four digits; fifth is dropped.
    key(12);
    key(1); key(2); key(3); key(4); key(5);
    check("t2_digits", {16'h0, bus.digits}, 32'h1234);
    check("t2_count", {29'h0, bus.entry_count}, 32'd4);
    check("t2_nopulse", pulses, 32'd0);
    check_display("t2", 16'h1234, 3'd4);

    // 3: operator captures the operand and clears entry.
    key(10);
    check("t3_pulses", pulses, 32'd1);
    check("t3_pulse_code", {28'h0, last_code}, 32'hA);
    check("t3_pulse_operand", {16'h0, last_operand}, 32'h1234);
    check("t3_op_code", {28'h0, bus.op_code}, 32'hA);
    check("t3_operand", {16'h0, bus.operand}, 32'h1234);
    check("t3_digits", {16'h0, bus.digits}, 32'h0);
    check("t3_count", {29'h0, bus.entry_count}, 32'd0);

    // 4: short bounce and a two-key chord are both rejected.
    key(1); key(2);
    press(16'h0080, 2, 4);
    press(16'h0088, 5, 4);
    check("t4_digits", {16'h0, bus.digits}, 32'h0012);
    check("t4_count", {29'h0, bus.entry_count}, 32'd2);

    // 5: backspace down to empty and beyond, then digit and clear.
    key(11);
    check("t5_bk1_digits", {16'h0, bus.digits}, 32'h0001);
    check("t5_bk1_count", {29'h0, bus.entry_count}, 32'd1);
    key(11);
    check("t5_bk2_digits", {16'h0, bus.digits}, 32'h0);
    check("t5_bk2_count", {29'h0, bus.entry_count}, 32'd0);
    key(11);
    check("t5_bk3_digits", {16'h0, bus.digits}, 32'h0);
    check("t5_bk3_count", {29'h0, bus.entry_count}, 32'd0);
    key(9);
    check("t5_nine", {16'h0, bus.digits}, 32'h0009);
    key(12);
    check("t5_clr_digits", {16'h0, bus.digits}, 32'h0);
    check("t5_clr_count", {29'h0, bus.entry_count}, 32'd0);
    check("t5_pulses", pulses, 32'd1);

    // 6: reset mid-debounce with the key held; a fresh full debounce is needed.
    key(3);
    check("t6_pre", {16'h0, bus.digits}, 32'h0003);
    @(negedge clk);
    bus.key_onehot = 16'h0040;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_digits", {16'h0, bus.digits}, 32'h0);
    check("t6_rst_count", {29'h0, bus.entry_count}, 32'd0);
    check("t6_rst_sel", {28'h0, bus.digit_sel}, 32'h8);
    check("t6_rst_operand", {16'h0, bus.operand}, 32'h0);
    check("t6_rst_code", {28'h0, bus.op_code}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t6_not_yet", {16'h0, bus.digits}, 32'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t6_accepted", {16'h0, bus.digits}, 32'h0006);
    bus.key_onehot = 16'h0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("t6_once_digits", {16'h0, bus.digits}, 32'h0006);
    check("t6_once_count", {29'h0, bus.entry_count}, 32'd1);

    check("final_pulses", pulses, 32'd1);
    check("monitor_errors", mon_errs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
